// File: rtl/quant_zigzag_buf_pkg.sv
// ---------------------------------------------------------------------------
// quant_pkg
// Shared types and constants for the quantizer back-end (quant_zigzag_buf).
//   OUT_W      : default quantized coefficient width
//   BLK_N      : coefficients per 8x8 block
//   coef_t     : signed quantized coefficient
//   ZZ_LUT     : zigzag position -> raster index within an 8x8 block
//   rd_state_t : read-side FSM states
// ---------------------------------------------------------------------------
package quant_pkg;

   localparam int OUT_W = 12;
   localparam int BLK_N = 64;

   typedef logic signed [OUT_W-1:0] coef_t;

   localparam logic [5:0] ZZ_LUT [0:63] = '{
       6'd0,  6'd1,  6'd8, 6'd16,  6'd9,  6'd2,  6'd3, 6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11,  6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13,  6'd6,  6'd7, 6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic {IDLE, STREAM} rd_state_t;

endpackage

// File: rtl/quant_zigzag_buf_float_to_sint.sv
// ---------------------------------------------------------------------------
// float_to_sint
// Two-stage pipelined conversion of an IEEE754 single-precision value to a
// symmetric-saturated signed OUT_W-bit integer.
//   Stage 1: decode exponent, align mantissa (optional rounding).
//   Stage 2: saturate magnitude, apply sign.
// Optional feature macro: QZ_ROUND_NEAREST_EN (round half away from zero);
// undefined = truncate toward zero.
// Ports:
//   clk       in   clock
//   nrst      in   asynchronous active-low reset (valid pipeline only)
//   din       in   32-bit float
//   din_valid in   din qualifier
//   q         out  signed OUT_W-bit result
//   q_valid   out  q qualifier
// ---------------------------------------------------------------------------
module float_to_sint #(
   parameter int OUT_W = 12
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [31:0]             din,
   input  logic                    din_valid,
   output logic signed [OUT_W-1:0] q,
   output logic                    q_valid
);

   localparam logic [OUT_W-1:0] MAG_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   // Biased exponent at which |value| >= 2^(OUT_W-1): always saturates.
   localparam logic [7:0] EXP_SAT = 8'(127 + OUT_W - 1);
`ifdef QZ_ROUND_NEAREST_EN
   // e == -1 still rounds up to 1.
   localparam logic [7:0] EXP_MIN = 8'd126;
`else
   localparam logic [7:0] EXP_MIN = 8'd127;
`endif

   // Align the 24-bit mantissa by sh = 23-e. The 25-bit intermediate keeps
   // the rounding carry so it can reach the saturation check.
   function automatic logic [OUT_W-1:0] shift_mag(input logic [23:0] m,
                                                  input logic [4:0]  sh);
      logic [24:0] t;
      t = {1'b0, m};
`ifdef QZ_ROUND_NEAREST_EN
      t = t + (25'd1 << (sh - 5'd1));
`endif
      t = t >> sh;
      return t[OUT_W-1:0];
   endfunction

   function automatic logic signed [OUT_W-1:0] sat_sign(input logic             sign,
                                                        input logic             sat,
                                                        input logic [OUT_W-1:0] mag);
      logic [OUT_W-1:0] m;
      m = (sat || (mag > MAG_MAX)) ? MAG_MAX : mag;
      return sign ? -$signed(m) : $signed(m);
   endfunction

   logic [7:0]       exp_in;
   logic [23:0]      m_in;
   logic [4:0]       sh_in;
   logic             sat_in;
   logic             zero_in;
   logic [OUT_W-1:0] mag_in;

   always_comb begin
      exp_in  = din[30:23];
      m_in    = {1'b1, din[22:0]};
      sh_in   = 5'(8'd150 - exp_in);
      sat_in  = (exp_in >= EXP_SAT);
      zero_in = (exp_in < EXP_MIN);
      mag_in  = (sat_in || zero_in) ? '0 : shift_mag(m_in, sh_in);
   end

   // ---- stage p1: decoded sign / saturate flag / aligned magnitude ----
   logic             sign_p1;
   logic             sat_p1;
   logic [OUT_W-1:0] mag_p1;
   logic             vld_p1;

   always_ff @(posedge clk) begin
      sign_p1 <= din[31];
      sat_p1  <= sat_in;
      mag_p1  <= mag_in;
   end

   // ---- stage p2: saturated, signed result ----
   logic signed [OUT_W-1:0] q_p2;
   logic                    vld_p2;

   always_ff @(posedge clk) begin
      q_p2 <= sat_sign(sign_p1, sat_p1, mag_p1);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= din_valid;
         vld_p2 <= vld_p1;
      end
   end

   assign q       = q_p2;
   assign q_valid = vld_p2;

endmodule

// File: rtl/quant_zigzag_buf.sv
// ---------------------------------------------------------------------------
// quant_zigzag_buf
// Quantizer back-end: converts float quotients to saturated signed integers,
// collects 8x8 blocks (raster order) in ping-pong banks and replays each
// block in JPEG zigzag order over a valid/ready stream.
// Optional feature macro: QZ_ROUND_NEAREST_EN (round-to-nearest conversion).
// Ports:
//   clk        in   clock
//   nrst       in   asynchronous active-low reset
//   din        in   32-bit float quotient, raster order
//   din_valid  in   din qualifier (no backpressure)
//   dout       out  signed OUT_W-bit coefficient, zigzag order
//   dout_valid out  dout qualifier
//   dout_ready in   consumer accept
//   dout_last  out  high with zigzag index 63
//   overflow   out  sticky: sample dropped because both banks were full
// ---------------------------------------------------------------------------
module quant_zigzag_buf #(
   parameter int OUT_W = 12
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [31:0]             din,
   input  logic                    din_valid,
   output logic signed [OUT_W-1:0] dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    dout_last,
   output logic                    overflow
);

   import quant_pkg::*;

   localparam logic [5:0] LAST_IDX = 6'(BLK_N - 1);

   logic signed [OUT_W-1:0] cvt_q;
   logic                    cvt_vld;

   float_to_sint #(.OUT_W(OUT_W)) u_cvt (
      .clk       (clk),
      .nrst      (nrst),
      .din       (din),
      .din_valid (din_valid),
      .q         (cvt_q),
      .q_valid   (cvt_vld)
   );

   // Two banks of 64 entries, addressed {bank, raster index}.
   logic signed [OUT_W-1:0] mem [0:2*BLK_N-1];

   logic [5:0] wr_idx;
   logic       wr_bank;
   logic [1:0] full;
   logic [1:0] full_n;
   logic       wr_ok;
   logic       set_full;
   logic       clr_full;

   assign wr_ok    = cvt_vld && !full[wr_bank];
   assign set_full = wr_ok && (wr_idx == LAST_IDX);

   // ---- write stage: store converted sample into the fill bank ----
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[{wr_bank, wr_idx}] <= cvt_q;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_idx   <= '0;
         wr_bank  <= 1'b0;
         overflow <= 1'b0;
      end else if (cvt_vld) begin
         if (full[wr_bank]) begin
            overflow <= 1'b1;
         end else begin
            wr_idx <= wr_idx + 6'd1;
            if (wr_idx == LAST_IDX)
               wr_bank <= ~wr_bank;
         end
      end
   end

   // Set and clear always target different banks: a bank is only written
   // while empty and only cleared while full.
   always_comb begin
      full_n = full;
      if (set_full)
         full_n[wr_bank] = 1'b1;
      if (clr_full)
         full_n[rd_bank] = 1'b0;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         full <= '0;
      else
         full <= full_n;
   end

   // ---- read FSM: dout is a registered read of the zigzag address ----
   rd_state_t  state, state_n;
   logic [5:0] rd_cnt, rd_cnt_n;
   logic       rd_bank, rd_bank_n;
   logic       fetch;
   logic       fetch_bank;
   logic [5:0] fetch_cnt;
   logic       valid_n;
   logic       last_n;
   logic       xfer;

   assign xfer = dout_valid && dout_ready;

   always_comb begin
      state_n    = state;
      rd_cnt_n   = rd_cnt;
      rd_bank_n  = rd_bank;
      fetch      = 1'b0;
      fetch_bank = rd_bank;
      fetch_cnt  = rd_cnt;
      clr_full   = 1'b0;
      valid_n    = dout_valid;
      last_n     = dout_last;
      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               state_n   = STREAM;
               rd_cnt_n  = '0;
               fetch     = 1'b1;
               fetch_cnt = '0;
               valid_n   = 1'b1;
            end
         end
         STREAM: begin
            if (xfer) begin
               if (rd_cnt == LAST_IDX) begin
                  clr_full  = 1'b1;
                  rd_bank_n = ~rd_bank;
                  rd_cnt_n  = '0;
                  // Other bank already complete: continue without a bubble.
                  if (full[~rd_bank]) begin
                     fetch      = 1'b1;
                     fetch_bank = ~rd_bank;
                     fetch_cnt  = '0;
                  end else begin
                     state_n = IDLE;
                     valid_n = 1'b0;
                     last_n  = 1'b0;
                  end
               end else begin
                  rd_cnt_n  = rd_cnt + 6'd1;
                  fetch     = 1'b1;
                  fetch_cnt = rd_cnt + 6'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (fetch)
         last_n = (fetch_cnt == LAST_IDX);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         rd_cnt     <= '0;
         rd_bank    <= 1'b0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
      end else begin
         state      <= state_n;
         rd_cnt     <= rd_cnt_n;
         rd_bank    <= rd_bank_n;
         dout_valid <= valid_n;
         dout_last  <= last_n;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         dout <= '0;
      else if (fetch)
         dout <= mem[{fetch_bank, ZZ_LUT[fetch_cnt]}];
   end

endmodule
